// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, types and helpers for the PS/2 scan-code decoder.
//   - prefix and modifier scan codes (set 2)
//   - list of protocol bytes that never form a key event
//   - decoder state enum
//   - scan_to_ascii(): set-2 make code to ASCII for the mapped key subset
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    // Keyboard responses / protocol bytes that carry no key information.
    localparam int PS2_N_IGNORED = 7;
    localparam logic [PS2_N_IGNORED-1:0][7:0] PS2_IGNORED =
        {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXT     = 2'b01,
        ST_BRK     = 2'b10,
        ST_EXT_BRK = 2'b11
    } ps2_state_e;

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_N_IGNORED; i++) begin
            if (code == PS2_IGNORED[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Returns 8'h00 for unmapped codes. Only letters honour 'upper'.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        case (code)
            8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
            8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
            8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
            8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
            8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
            8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
            // top-row digits
            8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
            8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
            8'h3E: c = 8'h38; 8'h46: c = 8'h39;
            // keypad digits
            8'h70: c = 8'h30; 8'h69: c = 8'h31; 8'h72: c = 8'h32; 8'h7A: c = 8'h33;
            8'h6B: c = 8'h34; 8'h73: c = 8'h35; 8'h74: c = 8'h36; 8'h6C: c = 8'h37;
            8'h75: c = 8'h38; 8'h7D: c = 8'h39;
            8'h29: c = 8'h20;
            8'h5A: c = 8'h0D;
            8'h66: c = 8'h08;
            default: c = 8'h00;
        endcase
        if (upper && (c >= 8'h61) && (c <= 8'h7A)) begin
            c = c - 8'h20;
        end else begin
            c = c;
        end
        return c;
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// ps2_ascii_rom: combinational scan-code to ASCII table.
//   code  in  8  set-2 make code (prefixes already stripped)
//   upper in  1  letters in upper case
//   ascii out 8  ASCII character, 8'h00 when the key is unmapped
module ps2_ascii_rom
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii
);

    // Table lookup.
    always_comb begin
        ascii = scan_to_ascii(code, upper);
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns the PS/2 receiver byte stream into key events.
// Strips E0/F0 prefixes, tracks Shift and Caps Lock, and emits ASCII for
// mapped non-extended make codes.
//   clk, rst              clock, async active-high reset
//   code_in, code_valid   received byte and its one-cycle strobe
//   key_code/ext/break    last event (registered, held until the next one)
//   key_valid             one-cycle event pulse
//   ascii, ascii_valid    ASCII of last make event / pulse on mapped makes
//   shift_o, caps_o       modifier state
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    output logic       shift_o,
    output logic       caps_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_e state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic timeout_s, emit_s, emit_ext_s, emit_brk_s, upper_s;
    logic [7:0] rom_ascii_s;
    logic lshift_held_r, rshift_held_r, caps_held_r, shift_r, caps_r;
    logic [7:0] key_code_r, ascii_r;
    logic key_ext_r, key_break_r, key_valid_r, ascii_valid_r;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_s = (state_r != ST_IDLE) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) && !code_valid;
    assign upper_s   = shift_r ^ caps_r;

    ps2_ascii_rom u_rom (
        .code  (code_in),
        .upper (upper_s),
        .ascii (rom_ascii_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and event decode.
    always_comb begin
        next_state_s = state_r;
        emit_s       = 1'b0;
        emit_ext_s   = 1'b0;
        emit_brk_s   = 1'b0;
        if (code_valid) begin
            if (is_ignored(code_in)) begin
                next_state_s = state_r;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (code_in == PS2_EXT) begin
                            next_state_s = ST_EXT;
                        end else if (code_in == PS2_BRK) begin
                            next_state_s = ST_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    ST_EXT: begin
                        if (code_in == PS2_EXT) begin
                            next_state_s = ST_EXT;
                        end else if (code_in == PS2_BRK) begin
                            next_state_s = ST_EXT_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            emit_ext_s   = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (code_in == PS2_BRK) begin
                            next_state_s = ST_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            emit_brk_s   = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (code_in == PS2_BRK) begin
                            next_state_s = ST_EXT_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            emit_ext_s   = 1'b1;
                            emit_brk_s   = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    default: begin
                        next_state_s = ST_IDLE;
                    end
                endcase
            end
        end else if (timeout_s) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = state_r;
        end
    end

    // Prefix timeout counter: runs only while a sequence is partial.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (code_valid || timeout_s || (state_r == ST_IDLE)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Event output registers; ascii holds across break events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_r    <= 8'h00;
            key_ext_r     <= 1'b0;
            key_break_r   <= 1'b0;
            key_valid_r   <= 1'b0;
            ascii_r       <= 8'h00;
            ascii_valid_r <= 1'b0;
        end else begin
            key_valid_r   <= emit_s;
            ascii_valid_r <= emit_s && !emit_ext_s && !emit_brk_s && (rom_ascii_s != 8'h00);
            if (emit_s) begin
                key_code_r  <= code_in;
                key_ext_r   <= emit_ext_s;
                key_break_r <= emit_brk_s;
                if (!emit_brk_s) begin
                    ascii_r <= emit_ext_s ? 8'h00 : rom_ascii_s;
                end
            end
        end
    end

    // Modifier tracking; the held bit stops Caps typematic repeats re-toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_held_r <= 1'b0;
            rshift_held_r <= 1'b0;
            shift_r       <= 1'b0;
            caps_held_r   <= 1'b0;
            caps_r        <= 1'b0;
        end else if (emit_s && !emit_ext_s) begin
            case (code_in)
                PS2_LSHIFT: begin
                    lshift_held_r <= !emit_brk_s;
                    shift_r       <= !emit_brk_s || rshift_held_r;
                end
                PS2_RSHIFT: begin
                    rshift_held_r <= !emit_brk_s;
                    shift_r       <= !emit_brk_s || lshift_held_r;
                end
                PS2_CAPS: begin
                    if (emit_brk_s) begin
                        caps_held_r <= 1'b0;
                    end else begin
                        caps_held_r <= 1'b1;
                        if (!caps_held_r) begin
                            caps_r <= ~caps_r;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign key_code    = key_code_r;
    assign key_ext     = key_ext_r;
    assign key_break   = key_break_r;
    assign key_valid   = key_valid_r;
    assign ascii       = ascii_r;
    assign ascii_valid = ascii_valid_r;
    assign shift_o     = shift_r;
    assign caps_o      = caps_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: expected events are queued as
// bytes are driven and compared when key_valid pulses.
module tb_ps2_scan_decoder;

    localparam int TMO = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] key_code, ascii;
    logic       key_ext, key_break, key_valid, ascii_valid, shift_o, caps_o;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       av;
        logic       chk_asc;
        logic [7:0] asc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ps2_scan_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .key_valid   (key_valid),
        .ascii       (ascii),
        .ascii_valid (ascii_valid),
        .shift_o     (shift_o),
        .caps_o      (caps_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] code, input logic ext, input logic brk,
                            input logic av, input logic chk_asc, input logic [7:0] asc);
        exp_t e;
        e.code = code; e.ext = ext; e.brk = brk; e.av = av; e.chk_asc = chk_asc; e.asc = asc;
        sb_q.push_back(e);
    endtask

    // One byte with a one-cycle idle gap after it.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code_in    = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_val({tag, "_event_timeout"}, sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_code"}, key_code, 8'h00);
        check_val({tag, "_ext"}, key_ext, 1'b0);
        check_val({tag, "_brk"}, key_break, 1'b0);
        check_val({tag, "_kv"}, key_valid, 1'b0);
        check_val({tag, "_ascii"}, ascii, 8'h00);
        check_val({tag, "_av"}, ascii_valid, 1'b0);
        check_val({tag, "_shift"}, shift_o, 1'b0);
        check_val({tag, "_caps"}, caps_o, 1'b0);
    endtask

    // Output monitor / scoreboard compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_key_valid", key_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("key_code", key_code, e.code);
                    check_val("key_ext", key_ext, e.ext);
                    check_val("key_break", key_break, e.brk);
                    check_val("ascii_valid", ascii_valid, e.av);
                    if (e.chk_asc) begin
                        check_val("ascii", ascii, e.asc);
                    end
                end
            end else begin
                check_val("ascii_valid_alone", ascii_valid, 1'b0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        code_in    = 8'h00;
        code_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Plain make
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61);
        send(8'h1C); drain("a");

        // Shift
        push_exp(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        send(8'h12); drain("lshift");
        check_val("shift_held", shift_o, 1'b1);
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41);
        send(8'h1C); drain("A_shift");
        push_exp(8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31);
        send(8'h16); drain("digit_shift");
        push_exp(8'h29, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20);
        send(8'h29); drain("space");
        send(8'hF0);
        push_exp(8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h12); drain("lshift_brk");
        check_val("shift_released", shift_o, 1'b0);
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61);
        send(8'h1C); drain("a_after_shift");

        // Caps with typematic repeat
        push_exp(8'h58, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        send(8'h58); drain("caps1");
        check_val("caps_on", caps_o, 1'b1);
        push_exp(8'h58, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        send(8'h58); drain("caps_rpt");
        check_val("caps_rpt_hold", caps_o, 1'b1);
        send(8'hF0);
        push_exp(8'h58, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h58); drain("caps_brk");
        check_val("caps_after_brk", caps_o, 1'b1);
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41);
        send(8'h1C); drain("A_caps");
        push_exp(8'h58, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        send(8'h58); drain("caps_off");
        check_val("caps_toggled_off", caps_o, 1'b0);
        send(8'hF0);
        push_exp(8'h58, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h58); drain("caps_off_brk");

        // Extended break, plain break
        send(8'hE0); send(8'hF0);
        push_exp(8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h75); drain("ext_brk");
        send(8'hF0);
        push_exp(8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h69); drain("kp1_brk");

        // Prefix timeout expires
        send(8'hE0);
        repeat (TMO + 5) @(negedge clk);
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61);
        send(8'h1C); drain("after_timeout");
        // Prefix still live just before the timeout
        send(8'hE0);
        repeat (TMO - 10) @(negedge clk);
        push_exp(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        send(8'h1C); drain("before_timeout");

        // Ignored bytes, then keypad digit
        send(8'hAA); send(8'hFA); send(8'hE1);
        push_exp(8'h69, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31);
        send(8'h69); drain("kp1");

        // Back-to-back strobes
        push_exp(8'h1A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7A);
        push_exp(8'h1B, 1'b0, 1'b0, 1'b1, 1'b1, 8'h73);
        @(negedge clk); code_in = 8'h1A; code_valid = 1'b1;
        @(negedge clk); code_in = 8'h1B;
        @(negedge clk); code_valid = 1'b0;
        drain("b2b");

        // Reset mid-sequence
        send(8'hF0);
        @(negedge clk); rst = 1'b1;
        #1 check_zero("rst_mid");
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b0;
        push_exp(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h61);
        send(8'h1C); drain("after_rst");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Converts the raw byte stream from the `ps2` receiver (`ps2_data_out`/`valid`) into key events. It strips the `E0` (extended) and `F0` (break) prefixes and tracks Shift and Caps Lock state. For a mapped subset of keys it produces ASCII. It sits directly downstream of `ps2` and upstream of any consumer of key events, such as a display or UART echo.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle clocks after a prefix byte before the partial sequence is dropped (2 ms at 50 MHz).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `code_in`  in  8  received byte; connects to `ps2_data_out`.
- `code_valid`  in  1  one-cycle strobe that `code_in` is new; connects to `valid`.
- `key_code`  out  8  scan code of the last event, prefixes removed.
- `key_ext`  out  1  last event was preceded by `E0`.
- `key_break`  out  1  last event was a release (preceded by `F0`).
- `key_valid`  out  1  one-cycle pulse: a complete event is on the outputs above.
- `ascii`  out  8  ASCII of the last make event; 0x00 if the key is unmapped.
- `ascii_valid`  out  1  one-cycle pulse, coincident with `key_valid`, only on a mapped, non-extended make.
- `shift_o`, `caps_o`  out  1 each  current modifier state.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- Transitions on `code_valid`:
  - IDLE: `E0` goes to EXT; `F0` goes to BRK.
  - EXT: `F0` goes to EXT_BRK.
  - Any other byte emits an event with ext/break taken from the current state, then returns to IDLE.
- Ignored bytes (no event, state unchanged): `E1`, `AA`, `FA`, `FE`, `EE`, `00`, `FF`. A repeated `E0` while in EXT and a repeated `F0` while in BRK or EXT_BRK are also ignored.
- Timeout: a counter clears on every `code_valid`. While the FSM is not in IDLE, the counter increments. When it reaches `TIMEOUT_CYCLES-1`, the FSM returns to IDLE with no event.
- Shift: tracks non-extended `12` and `59`. `shift_o` is 1 while either key is held; each key has its own held bit.
- Caps Lock: a non-extended `58` make toggles `caps_o` only if Caps is not already held. The `58` break clears the held bit, so typematic repeats do not toggle again.
- ASCII mapping covers non-extended codes only:
  - letters a–z, digits 0–9 (top row), keypad 0–9 (e.g. `69` maps to '1');
  - space `29` maps to 0x20, enter `5A` to 0x0D, backspace `66` to 0x08.
- Letters are uppercase when `shift_o ^ caps_o`. Digits are not affected by Shift.
- Modifier keys emit `key_valid` but never `ascii_valid`.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counter 0; held bits 0.
- Latency: `code_valid` in cycle N gives `key_valid`/`ascii_valid` in cycle N+1. Data outputs are registered and hold until the next event.
- Shift and Caps take effect for events decoded after the cycle in which the modifier event is emitted.
- When `code_valid` and timeout expiry occur in the same cycle, the byte is processed with the current state; the timeout is discarded.
- `rst` overrides everything, including mid-sequence (e.g. after `E0`, before the final byte).
- The input contract is one `code_valid` per byte, with strobes at least 2 cycles apart; back-to-back strobes are still processed correctly.

## Structure
- Package `ps2_pkg`:
  - prefix constants `PS2_EXT`=`E0`, `PS2_BRK`=`F0`;
  - modifier codes `12`, `59`, `58`;
  - ignored-code list;
  - state enum;
  - function `scan_to_ascii(code, upper)` returning 8 bits.
- One sub-module `ps2_ascii_rom`: a combinational case table wrapping `scan_to_ascii`. The FSM, counter and modifier logic stay in the top level.

## Test plan
- Send `1C` → after 1 cycle, `key_valid`=1, `key_code`=1C, ext=0, break=0, `ascii`=0x61, `ascii_valid`=1.
- Send `12`, then `1C`, then `F0 12`, then `1C` → ascii 0x41, then 0x61. Separately, send `58`, `58`, `F0 58`, then `1C` → `caps_o` stays 1, ascii 0x41.
- Send `E0 F0 75` → a single `key_valid` with `key_code`=75, ext=1, break=1, `ascii_valid`=0. Send `F0 69` → break=1, code 69, no ASCII.
- Send `E0`, wait `TIMEOUT_CYCLES`+5 clocks, then send `1C` → ext=0, ascii 0x61. Send `E0`, then `1C` after `TIMEOUT_CYCLES`-10 clocks → ext=1.
- Send `AA`, `FA`, `E1` → no `key_valid`. Send `69` (the ps2 bench byte) → ascii 0x31.
- Assert `rst` after `F0`, then release and send `1C` → make event, break=0. While `rst` is high, all outputs are 0.
